playback_sequencer: RTL and testbench
=====================================

# playback_sequencer

Top-level playback controller that sequences `song_reader` and the downstream note players. Converts debounced user pulses (play/pause, next, previous) and the `song_done` indication into the `play` level, the 2-bit `song` select, and a clean restart pulse (`reset_player`) whenever the track changes. Handles auto-advance at end of song, wrap-around, and an optional repeat-all mode. Sits between the button debouncers and `song_reader`.

## Interface
- `NUM_SONGS`, 4: number of songs in ROM, legal 1..4; song indices 0..NUM_SONGS-1.
- `RESET_CYCLES`, 2: width in cycles of the `reset_player` pulse on a track change, legal ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets all state.
- `play_button`  in  1  single-cycle pulse, toggles play/pause.
- `next_button`  in  1  single-cycle pulse, advance one song.
- `prev_button`  in  1  single-cycle pulse, go back one song.
- `repeat_mode`  in  1  level; 1 = wrap from last song to song 0 and keep playing.
- `song_done`  in  1  pulse from `song_reader`, current song finished.
- `play`  out  1  level to `song_reader`; 1 = advance notes.
- `song`  out  2  current song index to `song_reader`.
- `reset_player`  out  1  active-high restart to `song_reader`/note players.

## Operation
- States: PAUSED, PLAYING, SWITCH. Registered `ret_state` (PAUSED/PLAYING) records SWITCH exit target; counter `sw_cnt` of width $clog2(RESET_CYCLES+1).
- Reset (reset=0): state PAUSED, song=0, play=0, reset_player=0, sw_cnt=0, ret_state=PAUSED.
- Event priority within one cycle: `next_button` > `prev_button` > `song_done` > `play_button`; lower-priority events in that cycle are dropped.
- PAUSED: next → song=(song+1) mod NUM_SONGS, SWITCH, ret=PAUSED. prev → song=(song+NUM_SONGS-1) mod NUM_SONGS, SWITCH, ret=PAUSED. song_done ignored. play_button → PLAYING.
- PLAYING: next/prev → same song update, SWITCH, ret=PLAYING. song_done with song<NUM_SONGS-1 → song+1, SWITCH, ret=PLAYING. song_done with song=NUM_SONGS-1: repeat_mode=1 → song=0, ret=PLAYING; repeat_mode=0 → song=0, ret=PAUSED; both via SWITCH. play_button → PAUSED.
- SWITCH: reset_player=1, play=0; all inputs ignored (pulses lost, not queued). sw_cnt counts 0..RESET_CYCLES-1; on last count go to ret_state, sw_cnt=0.
- Outputs decoded from registered state: play=1 only in PLAYING; reset_player=1 only in SWITCH; song is a register.
- NUM_SONGS=1: next/prev/auto-advance keep song=0 but still perform SWITCH (restart).
- Song arithmetic is mod NUM_SONGS, never mod 4; song never holds a value ≥NUM_SONGS.
- Reset mid-SWITCH: aborts immediately to the reset values; no residual reset_player pulse.

## Timing
- Event sampled at edge E; new state/song visible in the cycle after E (1-cycle latency); no combinational input→output path.
- Track change: song takes its new value in the same cycle reset_player rises; reset_player=1 and play=0 for exactly RESET_CYCLES consecutive cycles; the following cycle play=1 if ret=PLAYING, else 0, and reset_player=0.
- Play/pause toggle: play changes one cycle after the pulse; no reset_player.
- song_done while PAUSED or SWITCH: no effect.
- Back-to-back pulses: a pulse in the cycle state enters PLAYING/PAUSED from SWITCH is accepted normally.

## Test plan
- Reset with reset=0 for 2 cycles, release → play=0, song=0, reset_player=0; play_button pulse → play=1 next cycle, song=0.
- PLAYING song 1, next_button → song=2, reset_player=1 and play=0 for 2 cycles (RESET_CYCLES=2), then play=1, reset_player=0.
- PLAYING song 3, repeat_mode=0, song_done → song=0, 2-cycle reset_player, end PAUSED with play=0; repeat with repeat_mode=1 → ends play=1 at song 0.
- PAUSED song 0, prev_button → song=3, SWITCH, ends PAUSED; NUM_SONGS=3 build → song=2.
- Same-cycle next_button+play_button while PLAYING song 0 → song=1, ends PLAYING (play pulse dropped); pulses during SWITCH → ignored, song unchanged.
- Reset asserted in 1st SWITCH cycle → next cycle song=0, play=0, reset_player=0, PAUSED.

Source files
------------

// File: rtl/playback_sequencer.sv
// Playback controller: turns button pulses and song_done into play/song/reset_player
// for song_reader, with auto-advance, wrap-around and optional repeat-all.
module playback_sequencer #(
    parameter int NUM_SONGS    = 4,
    parameter int RESET_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_button,
    input  logic       next_button,
    input  logic       prev_button,
    input  logic       repeat_mode,
    input  logic       song_done,
    output logic       play,
    output logic [1:0] song,
    output logic       reset_player
);

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        PLAYING = 2'd1,
        SWITCH  = 2'd2
    } state_e;

    localparam int               CNT_W     = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [1:0]       SONG_LAST = 2'(NUM_SONGS - 1);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [1:0]       song_q, song_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

    logic [1:0] song_next;
    logic [1:0] song_prev;
    logic       at_last;

    // Wrap explicitly at NUM_SONGS so song never leaves 0..NUM_SONGS-1.
    assign at_last   = (song_q == SONG_LAST);
    assign song_next = at_last ? 2'd0 : song_q + 2'd1;
    assign song_prev = (song_q == 2'd0) ? SONG_LAST : song_q - 2'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        ret_d    = ret_q;
        song_d   = song_q;
        sw_cnt_d = sw_cnt_q;

        unique case (state_q)
            PAUSED: begin
                if (next_button) begin
                    song_d  = song_next;
                    ret_d   = PAUSED;
                    state_d = SWITCH;
                end else if (prev_button) begin
                    song_d  = song_prev;
                    ret_d   = PAUSED;
                    state_d = SWITCH;
                end else if (play_button) begin
                    state_d = PLAYING;
                end
            end

            PLAYING: begin
                if (next_button) begin
                    song_d  = song_next;
                    ret_d   = PLAYING;
                    state_d = SWITCH;
                end else if (prev_button) begin
                    song_d  = song_prev;
                    ret_d   = PLAYING;
                    state_d = SWITCH;
                end else if (song_done) begin
                    // End of the last song stops playback unless repeat-all is on.
                    song_d  = song_next;
                    ret_d   = (at_last && !repeat_mode) ? PAUSED : PLAYING;
                    state_d = SWITCH;
                end else if (play_button) begin
                    state_d = PAUSED;
                end
            end

            SWITCH: begin
                if (sw_cnt_q == CNT_LAST) begin
                    sw_cnt_d = '0;
                    state_d  = ret_q;
                end else begin
                    sw_cnt_d = sw_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = PAUSED;
                ret_d    = PAUSED;
                song_d   = 2'd0;
                sw_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            state_q  <= PAUSED;
            ret_q    <= PAUSED;
            song_q   <= 2'd0;
            sw_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            song_q   <= song_d;
            sw_cnt_q <= sw_cnt_d;
        end
    end

    assign play         = (state_q == PLAYING);
    assign reset_player = (state_q == SWITCH);
    assign song         = song_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer: a 4-song/2-cycle build plus 3-song and
// 1-song builds for wrap and restart corner cases.
module tb_playback_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;

    logic       a_play_b = 0, a_next_b = 0, a_prev_b = 0, a_rep = 0, a_done = 0;
    logic       a_play, a_rp;
    logic [1:0] a_song;

    logic       b_play_b = 0, b_next_b = 0, b_prev_b = 0, b_rep = 0, b_done = 0;
    logic       b_play, b_rp;
    logic [1:0] b_song;

    logic       c_play_b = 0, c_next_b = 0, c_prev_b = 0, c_rep = 0, c_done = 0;
    logic       c_play, c_rp;
    logic [1:0] c_song;

    int checks   = 0;
    int failures = 0;

    playback_sequencer #(.NUM_SONGS(4), .RESET_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .play_button(a_play_b), .next_button(a_next_b), .prev_button(a_prev_b),
        .repeat_mode(a_rep), .song_done(a_done),
        .play(a_play), .song(a_song), .reset_player(a_rp)
    );

    playback_sequencer #(.NUM_SONGS(3), .RESET_CYCLES(1)) dut3 (
        .clk(clk), .reset(reset),
        .play_button(b_play_b), .next_button(b_next_b), .prev_button(b_prev_b),
        .repeat_mode(b_rep), .song_done(b_done),
        .play(b_play), .song(b_song), .reset_player(b_rp)
    );

    playback_sequencer #(.NUM_SONGS(1), .RESET_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset),
        .play_button(c_play_b), .next_button(c_next_b), .prev_button(c_prev_b),
        .repeat_mode(c_rep), .song_done(c_done),
        .play(c_play), .song(c_song), .reset_player(c_rp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {play, song, reset_player} so each comparison covers all outputs.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed={play,song,rp}=%b required=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pk(input logic p, input logic [1:0] s, input logic r);
        return {p, s, r};
    endfunction

    initial begin
        // Reset held for two cycles, then released.
        tick();
        tick();
        check("reset_hold", {a_play, a_song, a_rp}, pk(0, 2'd0, 0));
        reset = 1'b1;
        tick();
        check("reset_release", {a_play, a_song, a_rp}, pk(0, 2'd0, 0));
        check("reset_release_n3", {b_play, b_song, b_rp}, pk(0, 2'd0, 0));

        // Play toggle: play rises one cycle after the pulse, no restart.
        a_play_b = 1; tick(); a_play_b = 0;
        check("play_on", {a_play, a_song, a_rp}, pk(1, 2'd0, 0));

        // next: 0 -> 1, then 1 -> 2 with full 2-cycle restart window.
        a_next_b = 1; tick(); a_next_b = 0;
        check("next1_sw0", {a_play, a_song, a_rp}, pk(0, 2'd1, 1));
        tick();
        check("next1_sw1", {a_play, a_song, a_rp}, pk(0, 2'd1, 1));
        tick();
        check("next1_end", {a_play, a_song, a_rp}, pk(1, 2'd1, 0));

        a_next_b = 1; tick(); a_next_b = 0;
        check("next2_sw0", {a_play, a_song, a_rp}, pk(0, 2'd2, 1));
        tick();
        check("next2_sw1", {a_play, a_song, a_rp}, pk(0, 2'd2, 1));
        tick();
        check("next2_end", {a_play, a_song, a_rp}, pk(1, 2'd2, 0));

        a_next_b = 1; tick(); a_next_b = 0;
        tick(); tick();
        check("next3_end", {a_play, a_song, a_rp}, pk(1, 2'd3, 0));

        // song_done on last song without repeat: wrap to 0 and pause.
        a_done = 1; tick(); a_done = 0;
        check("done_last_sw0", {a_play, a_song, a_rp}, pk(0, 2'd0, 1));
        tick();
        check("done_last_sw1", {a_play, a_song, a_rp}, pk(0, 2'd0, 1));
        tick();
        check("done_last_paused", {a_play, a_song, a_rp}, pk(0, 2'd0, 0));

        // Play, prev to song 3 (keeps playing), then song_done with repeat.
        a_play_b = 1; tick(); a_play_b = 0;
        check("play_on2", {a_play, a_song, a_rp}, pk(1, 2'd0, 0));
        a_prev_b = 1; tick(); a_prev_b = 0;
        check("prev_play_sw0", {a_play, a_song, a_rp}, pk(0, 2'd3, 1));
        tick(); tick();
        check("prev_play_end", {a_play, a_song, a_rp}, pk(1, 2'd3, 0));
        a_rep = 1;
        a_done = 1; tick(); a_done = 0;
        check("repeat_sw0", {a_play, a_song, a_rp}, pk(0, 2'd0, 1));
        tick(); tick();
        check("repeat_end", {a_play, a_song, a_rp}, pk(1, 2'd0, 0));
        a_rep = 0;

        // Auto-advance mid-list keeps playing.
        a_done = 1; tick(); a_done = 0;
        check("auto_adv_sw0", {a_play, a_song, a_rp}, pk(0, 2'd1, 1));
        tick(); tick();
        check("auto_adv_end", {a_play, a_song, a_rp}, pk(1, 2'd1, 0));

        // Pause, then song_done while paused has no effect.
        a_play_b = 1; tick(); a_play_b = 0;
        check("pause", {a_play, a_song, a_rp}, pk(0, 2'd1, 0));
        a_done = 1; tick(); a_done = 0;
        check("done_paused", {a_play, a_song, a_rp}, pk(0, 2'd1, 0));

        // prev while paused: 1 -> 0, then 0 -> 3 wrap, ending paused.
        a_prev_b = 1; tick(); a_prev_b = 0;
        tick(); tick();
        check("prev_paused_0", {a_play, a_song, a_rp}, pk(0, 2'd0, 0));
        a_prev_b = 1; tick(); a_prev_b = 0;
        check("prev_wrap_sw0", {a_play, a_song, a_rp}, pk(0, 2'd3, 1));
        tick();
        check("prev_wrap_sw1", {a_play, a_song, a_rp}, pk(0, 2'd3, 1));
        tick();
        check("prev_wrap_end", {a_play, a_song, a_rp}, pk(0, 2'd3, 0));

        // Play, then next wraps 3 -> 0 while playing.
        a_play_b = 1; tick(); a_play_b = 0;
        a_next_b = 1; tick(); a_next_b = 0;
        check("next_wrap_sw0", {a_play, a_song, a_rp}, pk(0, 2'd0, 1));
        tick(); tick();
        check("next_wrap_end", {a_play, a_song, a_rp}, pk(1, 2'd0, 0));

        // next + play together: play dropped. Pulses inside SWITCH are lost.
        a_next_b = 1; a_play_b = 1; tick(); a_next_b = 0; a_play_b = 0;
        check("np_sw0", {a_play, a_song, a_rp}, pk(0, 2'd1, 1));
        a_next_b = 1; a_play_b = 1; a_done = 1; a_prev_b = 1;
        tick();
        a_next_b = 0; a_play_b = 0; a_done = 0; a_prev_b = 0;
        check("np_sw1_ignored", {a_play, a_song, a_rp}, pk(0, 2'd1, 1));
        tick();
        check("np_end_playing", {a_play, a_song, a_rp}, pk(1, 2'd1, 0));

        // Pulse in the first cycle back in PLAYING is accepted.
        a_play_b = 1; tick(); a_play_b = 0;
        check("b2b_pause", {a_play, a_song, a_rp}, pk(0, 2'd1, 0));

        // Priority: prev beats song_done and play_button.
        a_play_b = 1; tick(); a_play_b = 0;
        a_prev_b = 1; a_done = 1; a_play_b = 1; tick();
        a_prev_b = 0; a_done = 0; a_play_b = 0;
        check("prio_prev_sw0", {a_play, a_song, a_rp}, pk(0, 2'd0, 1));
        tick(); tick();
        check("prio_prev_end", {a_play, a_song, a_rp}, pk(1, 2'd0, 0));

        // Reset in first SWITCH cycle aborts straight to reset values.
        a_next_b = 1; tick(); a_next_b = 0;
        check("rst_mid_sw0", {a_play, a_song, a_rp}, pk(0, 2'd1, 1));
        reset = 1'b0; tick(); reset = 1'b1;
        check("rst_mid_abort", {a_play, a_song, a_rp}, pk(0, 2'd0, 0));
        tick();
        check("rst_mid_after", {a_play, a_song, a_rp}, pk(0, 2'd0, 0));
        a_play_b = 1; tick(); a_play_b = 0;
        check("rst_mid_paused", {a_play, a_song, a_rp}, pk(1, 2'd0, 0));

        // NUM_SONGS=3, RESET_CYCLES=1: prev from 0 gives 2, one-cycle restart.
        b_prev_b = 1; tick(); b_prev_b = 0;
        check("n3_prev_sw0", {b_play, b_song, b_rp}, pk(0, 2'd2, 1));
        tick();
        check("n3_prev_end", {b_play, b_song, b_rp}, pk(0, 2'd2, 0));
        b_play_b = 1; tick(); b_play_b = 0;
        b_next_b = 1; tick(); b_next_b = 0;
        check("n3_next_wrap_sw0", {b_play, b_song, b_rp}, pk(0, 2'd0, 1));
        tick();
        check("n3_next_wrap_end", {b_play, b_song, b_rp}, pk(1, 2'd0, 0));
        b_done = 1; tick(); b_done = 0; tick();
        b_done = 1; tick(); b_done = 0; tick();
        check("n3_auto_to_2", {b_play, b_song, b_rp}, pk(1, 2'd2, 0));
        b_done = 1; tick(); b_done = 0;
        check("n3_done_last_sw0", {b_play, b_song, b_rp}, pk(0, 2'd0, 1));
        tick();
        check("n3_done_last_end", {b_play, b_song, b_rp}, pk(0, 2'd0, 0));

        // NUM_SONGS=1, RESET_CYCLES=3: next still restarts, song stays 0.
        c_play_b = 1; tick(); c_play_b = 0;
        c_next_b = 1; tick(); c_next_b = 0;
        check("n1_sw0", {c_play, c_song, c_rp}, pk(0, 2'd0, 1));
        tick(); tick();
        check("n1_sw2", {c_play, c_song, c_rp}, pk(0, 2'd0, 1));
        tick();
        check("n1_end", {c_play, c_song, c_rp}, pk(1, 2'd0, 0));
        c_done = 1; tick(); c_done = 0;
        check("n1_done_sw0", {c_play, c_song, c_rp}, pk(0, 2'd0, 1));
        tick(); tick(); tick();
        check("n1_done_end_paused", {c_play, c_song, c_rp}, pk(0, 2'd0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
